// File: rtl/palm_locator.sv
// palm_locator: finds the palm bounding box in a binary raster-order pixel stream.
// A row qualifies when it holds at least ROW_MIN_PIXELS white pixels. The box spans
// every qualifying row and the widest white extent among those rows. The box is
// published one cycle after the last pixel of a frame and held until the next publish.
// palm_width == 0 means "no palm".
// Optional build macro PALM_LOCATOR_HOLD_EN: a frame with too few qualifying rows
// leaves the geometry outputs unchanged and does not pulse palm_valid.
//
// Handshake: a pixel is accepted on any clk edge where pixel_valid is high while
// scanning, or where pixel_valid && sof are both high (frame start, any state).
// There is no back-pressure. palm_valid is a one-cycle strobe with no ready.
module palm_locator #(
  parameter int IMAGE_WIDTH    = 120,
  parameter int IMAGE_HEIGHT   = 160,
  parameter int ROW_MIN_PIXELS = 20,
  parameter int MIN_ROWS       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       object_image,
  input  logic       pixel_valid,
  input  logic       sof,
  output logic [7:0] palm_width,
  output logic [7:0] palm_height,
  output logic [7:0] start_of_palm_r,
  output logic [7:0] start_of_palm_c,
  output logic [7:0] end_of_palm_r,
  output logic [7:0] end_of_palm_c,
  output logic       palm_valid,
  output logic       frame_err,
  output logic [1:0] dbg_state
);

  localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [7:0]    ROW_MIN  = 8'(ROW_MIN_PIXELS);
  localparam logic [7:0]    QUAL_MIN = 8'(MIN_ROWS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Raster position of the next pixel to be accepted
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  // Per-row accumulators
  logic [7:0]    r_cnt;
  logic [CW-1:0] r_first;
  logic [CW-1:0] r_last;
  logic          r_seen;

  // Per-frame box accumulators (valid only while r_qual != 0)
  logic [RW-1:0] r_box_r0;
  logic [RW-1:0] r_box_r1;
  logic [CW-1:0] r_box_c0;
  logic [CW-1:0] r_box_c1;
  logic [7:0]    r_qual;

  // End-of-frame snapshot consumed in LATCH
  logic [RW-1:0] r_snap_r0;
  logic [RW-1:0] r_snap_r1;
  logic [CW-1:0] r_snap_c0;
  logic [CW-1:0] r_snap_c1;
  logic [7:0]    r_snap_qual;

  // Combinational view of the current pixel
  logic          w_start;
  logic          w_accept;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [7:0]    w_cnt_b;
  logic [CW-1:0] w_first_b;
  logic [CW-1:0] w_last_b;
  logic          w_seen_b;
  logic [RW-1:0] w_box_r0_b;
  logic [RW-1:0] w_box_r1_b;
  logic [CW-1:0] w_box_c0_b;
  logic [CW-1:0] w_box_c1_b;
  logic [7:0]    w_qual_b;
  logic [7:0]    w_cnt_n;
  logic [CW-1:0] w_first_n;
  logic [CW-1:0] w_last_n;
  logic          w_seen_n;
  logic          w_row_end;
  logic          w_eof;
  logic          w_row_qual;
  logic [RW-1:0] w_box_r0_n;
  logic [RW-1:0] w_box_r1_n;
  logic [CW-1:0] w_box_c0_n;
  logic [CW-1:0] w_box_c1_n;
  logic [7:0]    w_qual_n;

  assign dbg_state = r_state;

  // Fold the current pixel into row and frame accumulators; a sof pixel starts from a clean slate
  always_comb begin
    w_start  = pixel_valid && sof;
    w_accept = pixel_valid && (sof || (r_state == S_SCAN));

    w_col      = w_start ? '0 : r_col;
    w_row      = w_start ? '0 : r_row;
    w_cnt_b    = w_start ? '0 : r_cnt;
    w_first_b  = w_start ? '0 : r_first;
    w_last_b   = w_start ? '0 : r_last;
    w_seen_b   = w_start ? 1'b0 : r_seen;
    w_box_r0_b = w_start ? '0 : r_box_r0;
    w_box_r1_b = w_start ? '0 : r_box_r1;
    w_box_c0_b = w_start ? '0 : r_box_c0;
    w_box_c1_b = w_start ? '0 : r_box_c1;
    w_qual_b   = w_start ? '0 : r_qual;

    w_cnt_n   = w_cnt_b;
    w_first_n = w_first_b;
    w_last_n  = w_last_b;
    w_seen_n  = w_seen_b;
    if (object_image) begin
      w_cnt_n  = (w_cnt_b == 8'hFF) ? 8'hFF : w_cnt_b + 8'd1;
      w_last_n = w_col;
      w_seen_n = 1'b1;
      if (!w_seen_b) begin
        w_first_n = w_col;
      end
    end

    w_row_end  = (w_col == COL_LAST);
    w_eof      = w_row_end && (w_row == ROW_LAST);
    w_row_qual = w_row_end && (w_cnt_n >= ROW_MIN);

    w_box_r0_n = w_box_r0_b;
    w_box_r1_n = w_box_r1_b;
    w_box_c0_n = w_box_c0_b;
    w_box_c1_n = w_box_c1_b;
    w_qual_n   = w_qual_b;
    if (w_row_qual) begin
      w_box_r1_n = w_row;
      w_qual_n   = (w_qual_b == 8'hFF) ? 8'hFF : w_qual_b + 8'd1;
      if (w_qual_b == 8'd0) begin
        w_box_r0_n = w_row;
        w_box_c0_n = w_first_n;
        w_box_c1_n = w_last_n;
      end else begin
        w_box_c0_n = (w_first_n < w_box_c0_b) ? w_first_n : w_box_c0_b;
        w_box_c1_n = (w_last_n  > w_box_c1_b) ? w_last_n  : w_box_c1_b;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state: any accepted pixel keeps scanning unless it closes the frame
  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      w_next = w_eof ? S_LATCH : S_SCAN;
    end else if (r_state == S_LATCH) begin
      w_next = S_IDLE;
    end
  end

  // Raster position, row/frame accumulators and end-of-frame snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_cnt       <= '0;
      r_first     <= '0;
      r_last      <= '0;
      r_seen      <= 1'b0;
      r_box_r0    <= '0;
      r_box_r1    <= '0;
      r_box_c0    <= '0;
      r_box_c1    <= '0;
      r_qual      <= '0;
      r_snap_r0   <= '0;
      r_snap_r1   <= '0;
      r_snap_c0   <= '0;
      r_snap_c1   <= '0;
      r_snap_qual <= '0;
    end else if (w_accept) begin
      if (w_row_end) begin
        r_col   <= '0;
        r_cnt   <= '0;
        r_first <= '0;
        r_last  <= '0;
        r_seen  <= 1'b0;
        if (w_eof) begin
          r_row       <= '0;
          r_box_r0    <= '0;
          r_box_r1    <= '0;
          r_box_c0    <= '0;
          r_box_c1    <= '0;
          r_qual      <= '0;
          r_snap_r0   <= w_box_r0_n;
          r_snap_r1   <= w_box_r1_n;
          r_snap_c0   <= w_box_c0_n;
          r_snap_c1   <= w_box_c1_n;
          r_snap_qual <= w_qual_n;
        end else begin
          r_row    <= w_row + 1'b1;
          r_box_r0 <= w_box_r0_n;
          r_box_r1 <= w_box_r1_n;
          r_box_c0 <= w_box_c0_n;
          r_box_c1 <= w_box_c1_n;
          r_qual   <= w_qual_n;
        end
      end else begin
        r_col    <= w_col + 1'b1;
        r_row    <= w_row;
        r_cnt    <= w_cnt_n;
        r_first  <= w_first_n;
        r_last   <= w_last_n;
        r_seen   <= w_seen_n;
        r_box_r0 <= w_box_r0_n;
        r_box_r1 <= w_box_r1_n;
        r_box_c0 <= w_box_c0_n;
        r_box_c1 <= w_box_c1_n;
        r_qual   <= w_qual_n;
      end
    end
  end

  // Publish the snapshot on the LATCH edge; outputs otherwise hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      palm_width      <= '0;
      palm_height     <= '0;
      start_of_palm_r <= '0;
      start_of_palm_c <= '0;
      end_of_palm_r   <= '0;
      end_of_palm_c   <= '0;
      palm_valid      <= 1'b0;
    end else begin
      palm_valid <= 1'b0;
      if (r_state == S_LATCH) begin
        if (r_snap_qual >= QUAL_MIN) begin
          palm_width      <= 8'(r_snap_c1) - 8'(r_snap_c0) + 8'd1;
          palm_height     <= 8'(r_snap_r1) - 8'(r_snap_r0) + 8'd1;
          start_of_palm_r <= 8'(r_snap_r0);
          start_of_palm_c <= 8'(r_snap_c0);
          end_of_palm_r   <= 8'(r_snap_r1);
          end_of_palm_c   <= 8'(r_snap_c1);
          palm_valid      <= 1'b1;
        end else begin
`ifdef PALM_LOCATOR_HOLD_EN
          palm_valid      <= 1'b0;
`else
          palm_width      <= '0;
          palm_height     <= '0;
          start_of_palm_r <= '0;
          start_of_palm_c <= '0;
          end_of_palm_r   <= '0;
          end_of_palm_c   <= '0;
          palm_valid      <= 1'b1;
`endif
        end
      end
    end
  end

  // Sticky abort flag: a new frame started before the current one finished
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
    end else if ((r_state == S_SCAN) && w_start) begin
      frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_palm_locator.sv
// Testbench for palm_locator. Geometry is reduced (64x40) to keep frames short;
// row/rows thresholds keep their default values.
module tb_palm_locator;

  localparam int W    = 64;
  localparam int H    = 40;
  localparam int RMIN = 20;
  localparam int QMIN = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       object_image;
  logic       pixel_valid;
  logic       sof;
  logic [7:0] palm_width;
  logic [7:0] palm_height;
  logic [7:0] start_of_palm_r;
  logic [7:0] start_of_palm_c;
  logic [7:0] end_of_palm_r;
  logic [7:0] end_of_palm_c;
  logic       palm_valid;
  logic       frame_err;
  logic [1:0] dbg_state;

  palm_locator #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ROW_MIN_PIXELS(RMIN), .MIN_ROWS(QMIN)
  ) dut (
    .clk(clk), .rst(rst), .object_image(object_image), .pixel_valid(pixel_valid), .sof(sof),
    .palm_width(palm_width), .palm_height(palm_height),
    .start_of_palm_r(start_of_palm_r), .start_of_palm_c(start_of_palm_c),
    .end_of_palm_r(end_of_palm_r), .end_of_palm_c(end_of_palm_c),
    .palm_valid(palm_valid), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          n_pulse = 0;
  int          n_exp_pub = 0;
  logic        prev_pv = 1'b0;
  logic [47:0] exp_q[$];
  logic [47:0] got;

  assign got = {palm_width, palm_height, start_of_palm_r, start_of_palm_c,
                end_of_palm_r, end_of_palm_c};

  function automatic logic [47:0] pk(int w, int h, int r0, int c0, int r1, int c1);
    return {8'(w), 8'(h), 8'(r0), 8'(c0), 8'(r1), 8'(c1)};
  endfunction

  localparam logic [47:0] E0 = {8'd40, 8'd20, 8'd12, 8'd10, 8'd31, 8'd49};
  localparam logic [47:0] E3 = {8'd25, 8'd10, 8'd25, 8'd5,  8'd34, 8'd29};
  localparam logic [47:0] E4 = {8'd20, 8'd10, 8'd30, 8'd44, 8'd39, 8'd63};
  localparam logic [47:0] E5 = {8'd64, 8'd40, 8'd0,  8'd0,  8'd39, 8'd63};
  localparam logic [47:0] Z  = 48'd0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every palm_valid strobe pops one expected box
  always @(negedge clk) begin
    if (!rst && palm_valid) begin
      n_pulse++;
      check("pulse_single_cycle", {47'd0, prev_pv}, 48'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_publish: got %h, required no publish", got);
      end else begin
        check("publish_box", got, exp_q.pop_front());
      end
    end
    prev_pv = palm_valid;
  end

  // ---------------- image model ----------------
  function automatic logic px(int img, int r, int c);
    case (img)
      0: return (r >= 12 && r <= 31 && c >= 10 && c <= 49);
      2: return (r >= 2 && r <= 20 && c >= 40 && c <= 58) ||
                (r >= 25 && r <= 29 && c >= 5 && c <= 29);
      3: return (r >= 2 && r <= 20 && c >= 40 && c <= 58) ||
                (r >= 25 && r <= 34 && c >= 5 && c <= 29);
      4: return (r >= 30 && c >= 44) || (r == 29 && c <= 18);
      5: return (r <= 4 && c <= 24) || (r >= 35 && c >= 40);
      6: return (r >= 3 && r <= 11 && c >= 20 && c <= 39);
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_px(input logic v, input logic s, input logic p);
    @(negedge clk);
    pixel_valid  = v;
    sof          = s;
    object_image = p;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_px(1'b0, 1'b0, 1'b0);
  endtask

  // Sends rows 0..nrows-1; gaps inserts one idle cycle before every pixel
  task automatic send_rows(input int img, input int nrows, input bit gaps,
                           input bit hold_chk, input logic [47:0] hold_exp);
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gaps) begin
          drive_px(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          if (hold_chk && r == H / 2 && c == 0) begin
            #1 check("held_during_gap", got, hold_exp);
          end
        end
        drive_px(1'b1, (r == 0 && c == 0), px(img, r, c));
      end
    end
  endtask

  task automatic wait_publish(input int target);
    for (int k = 0; k < 8 && n_pulse < target; k++) begin
      @(negedge clk);
      #1;
    end
    check("publish_seen", 48'(n_pulse >= target), 48'd1);
  endtask

  task automatic frame_expect(input int img, input bit pub, input logic [47:0] exp);
    int base;
    base = n_pulse;
    if (pub) begin
      exp_q.push_back(exp);
      n_exp_pub++;
    end
    send_rows(img, H, 1'b0, 1'b0, Z);
    idle(1);
    if (pub) begin
      wait_publish(base + 1);
    end else begin
      idle(4);
      check("no_publish", 48'(n_pulse), 48'(base));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    rst = 1'b1;
    pixel_valid = 1'b0;
    sof = 1'b0;
    object_image = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_geometry", got, Z);
    check("reset_palm_valid", 48'(palm_valid), 48'd0);
    check("reset_frame_err", 48'(frame_err), 48'd0);
    check("reset_state_idle", 48'(dbg_state), 48'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);

    // Rectangle, continuous valid, with exact publish latency
    exp_q.push_back(E0);
    n_exp_pub++;
    send_rows(0, H, 1'b0, 1'b0, Z);
    drive_px(1'b0, 1'b0, 1'b0);
    #1 check("latency_not_early", 48'(palm_valid), 48'd0);
    drive_px(1'b0, 1'b0, 1'b0);
    #1 check("latency_one_cycle", 48'(palm_valid), 48'd1);
    idle(3);
    check("rect_geometry_held", got, E0);

`ifdef PALM_LOCATOR_HOLD_EN
    frame_expect(1, 1'b0, Z);
    check("black_holds_box", got, E0);
    frame_expect(2, 1'b0, Z);
    frame_expect(3, 1'b1, E3);
    frame_expect(6, 1'b0, Z);
    check("nine_rows_holds_box", got, E3);
`else
    frame_expect(1, 1'b1, Z);
    frame_expect(2, 1'b1, Z);
    frame_expect(3, 1'b1, E3);
    frame_expect(6, 1'b1, Z);
`endif
    frame_expect(4, 1'b1, E4);

    // Rectangle with 50% valid duty cycle; outputs must hold during gaps
    base = n_pulse;
    exp_q.push_back(E0);
    n_exp_pub++;
    send_rows(0, H, 1'b1, 1'b1, E4);
    idle(1);
    wait_publish(base + 1);

    // Early sof aborts a partial frame; the restarted frame publishes
    check("frame_err_before_abort", 48'(frame_err), 48'd0);
    send_rows(5, 20, 1'b0, 1'b0, Z);
    frame_expect(0, 1'b1, E0);
    check("frame_err_after_abort", 48'(frame_err), 48'd1);

    // Back-to-back frames: second sof arrives in the LATCH cycle
    base = n_pulse;
    exp_q.push_back(E4);
    exp_q.push_back(E5);
    n_exp_pub += 2;
    send_rows(4, H, 1'b0, 1'b0, Z);
    send_rows(5, H, 1'b0, 1'b0, Z);
    idle(1);
    wait_publish(base + 2);
    check("back_to_back_final", got, E5);

    // Asynchronous reset mid-frame clears outputs immediately
    send_rows(0, 26, 1'b0, 1'b0, Z);
    #2 rst = 1'b1;
    pixel_valid = 1'b0;
    #1;
    check("async_rst_geometry", got, Z);
    check("async_rst_frame_err", 48'(frame_err), 48'd0);
    check("async_rst_state", 48'(dbg_state), 48'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);
    frame_expect(0, 1'b1, E0);

    idle(5);
    check("queue_drained", 48'(exp_q.size()), 48'd0);
    check("publish_count", 48'(n_pulse), 48'(n_exp_pub));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
